// File: rtl/spi_ram_if.sv
// spi_ram_if: command/response bundle between an SPI slave front end and spi_ram
interface spi_ram_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;
  logic       cmd_err;
  modport master (output din, rx_valid, input dout, tx_valid, cmd_err);
  modport slave (input din, rx_valid, output dout, tx_valid, cmd_err);
endinterface

// File: rtl/spi_ram.sv
// spi_ram: byte RAM addressed by 2-bit SPI commands with separate write/read address registers
module spi_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8,
  parameter int AUTO_INC  = 0
) (
  input logic        clk,
  input logic        rst_n,
  spi_ram_if.slave   bus
);
  logic [7:0] mem [MEM_DEPTH];
  logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
  logic wr_addr_ok, rd_addr_ok, addr_bad;
  assign addr_bad = 32'(bus.din[7:0]) >= MEM_DEPTH;
  function automatic logic [ADDR_SIZE-1:0] inc(input logic [ADDR_SIZE-1:0] a);
    return (32'(a) == MEM_DEPTH - 1) ? '0 : a + 1'b1;
  endfunction
  // memory is deliberately left out of reset so contents survive it
  always_ff @(posedge clk)
    if (rst_n && bus.rx_valid && bus.din[9:8] == 2'b01 && wr_addr_ok)
      mem[wr_addr] <= bus.din[7:0];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.dout     <= '0;
      bus.tx_valid <= 1'b0;
      bus.cmd_err  <= 1'b0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      wr_addr_ok   <= 1'b0;
      rd_addr_ok   <= 1'b0;
    end else begin
      bus.cmd_err <= 1'b0;
      if (bus.rx_valid) begin
        // rejected commands only raise cmd_err; all other state holds
        case (bus.din[9:8])
          2'b00: if (addr_bad) bus.cmd_err <= 1'b1;
                 else begin
                   wr_addr      <= bus.din[ADDR_SIZE-1:0];
                   wr_addr_ok   <= 1'b1;
                   bus.tx_valid <= 1'b0;
                 end
          2'b01: if (!wr_addr_ok) bus.cmd_err <= 1'b1;
                 else begin
                   if (AUTO_INC != 0) wr_addr <= inc(wr_addr);
                   bus.tx_valid <= 1'b0;
                 end
          2'b10: if (addr_bad) bus.cmd_err <= 1'b1;
                 else begin
                   rd_addr      <= bus.din[ADDR_SIZE-1:0];
                   rd_addr_ok   <= 1'b1;
                   bus.tx_valid <= 1'b0;
                 end
          default: if (!rd_addr_ok) bus.cmd_err <= 1'b1;
                   else begin
                     bus.dout     <= mem[rd_addr];
                     bus.tx_valid <= 1'b1;
                     if (AUTO_INC != 0) rd_addr <= inc(rd_addr);
                   end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_spi_ram.sv
// tb_spi_ram: scoreboard bench driving three spi_ram configurations from one command stream
module tb_spi_ram;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_valid = 1'b0;
  logic [9:0] din = '0;
  always #5 clk = ~clk;

  spi_ram_if if0 ();
  spi_ram_if if1 ();
  spi_ram_if if2 ();
  assign if0.din = din;
  assign if1.din = din;
  assign if2.din = din;
  assign if0.rx_valid = rx_valid;
  assign if1.rx_valid = rx_valid;
  assign if2.rx_valid = rx_valid;

  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  spi_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  spi_ram #(.MEM_DEPTH(128), .ADDR_SIZE(7), .AUTO_INC(1)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  typedef struct packed {
    logic [2:0][7:0] d;
    logic [2:0]      t;
    logic [2:0]      e;
  } exp_t;
  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  int  dep [3] = '{256, 256, 128};
  bit  ainc[3] = '{1'b0, 1'b1, 1'b1};
  int  m_mem[3][256];
  int  wa[3], ra[3], dq[3];
  bit  wok[3], rok[3], tv[3];

  // reference: the state each configuration must show after the next clock edge
  task automatic model_step(input bit r, input bit v, input logic [9:0] d);
    exp_t x;
    int p;
    p = int'(d[7:0]);
    for (int i = 0; i < 3; i++) begin
      x.e[i] = 1'b0;
      if (r) begin
        wa[i] = 0; ra[i] = 0; wok[i] = 0; rok[i] = 0; dq[i] = 0; tv[i] = 0;
      end else if (v) begin
        if (d[9:8] == 2'd0) begin
          if (p >= dep[i]) x.e[i] = 1'b1;
          else begin wa[i] = p; wok[i] = 1; tv[i] = 0; end
        end else if (d[9:8] == 2'd1) begin
          if (!wok[i]) x.e[i] = 1'b1;
          else begin
            m_mem[i][wa[i]] = p;
            if (ainc[i]) wa[i] = (wa[i] + 1) % dep[i];
            tv[i] = 0;
          end
        end else if (d[9:8] == 2'd2) begin
          if (p >= dep[i]) x.e[i] = 1'b1;
          else begin ra[i] = p; rok[i] = 1; tv[i] = 0; end
        end else begin
          if (!rok[i]) x.e[i] = 1'b1;
          else begin
            dq[i] = m_mem[i][ra[i]];
            tv[i] = 1;
            if (ainc[i]) ra[i] = (ra[i] + 1) % dep[i];
          end
        end
      end
      x.d[i] = 8'(dq[i]);
      x.t[i] = tv[i];
    end
    q.push_back(x);
  endtask

  task automatic cyc(input bit r, input bit v, input logic [9:0] d);
    @(negedge clk);
    rst_n = !r;
    rx_valid = v;
    din = d;
    model_step(r, v, d);
  endtask
  task automatic cmd(input logic [1:0] c, input logic [7:0] p);
    cyc(1'b0, 1'b1, {c, p});
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 10'h0);
  endtask

  // monitor: one expected entry per clock edge, compared just after the edge
  initial begin
    logic [2:0][7:0] ad;
    logic [2:0] at, ae;
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        ad = {if2.dout, if1.dout, if0.dout};
        at = {if2.tx_valid, if1.tx_valid, if0.tx_valid};
        ae = {if2.cmd_err, if1.cmd_err, if0.cmd_err};
        for (int i = 0; i < 3; i++) begin
          compared++;
          if (ad[i] !== x.d[i] || at[i] !== x.t[i] || ae[i] !== x.e[i]) begin
            mismatched++;
            $display("FAIL inst%0d t=%0t dout/tx_valid/cmd_err got %h/%b/%b want %h/%b/%b",
                     i, $time, ad[i], at[i], ae[i], x.d[i], x.t[i], x.e[i]);
          end
        end
      end
    end
  end

  initial begin
    cyc(1'b1, 1'b0, 10'h0);
    cyc(1'b1, 1'b0, 10'h0);
    cmd(2'd1, 8'h77);
    cmd(2'd3, 8'h00);
    idle(2);
    for (int a = 0; a < 256; a++) begin
      cmd(2'd0, 8'(a));
      cmd(2'd1, 8'($urandom));
    end
    cmd(2'd0, 8'h2A); cmd(2'd1, 8'h5C); cmd(2'd2, 8'h2A); cmd(2'd3, 8'h00);
    idle(10);
    cmd(2'd0, 8'h01);
    idle(1);
    cmd(2'd0, 8'hFF); cmd(2'd1, 8'h11); cmd(2'd1, 8'h22);
    cmd(2'd2, 8'hFF); cmd(2'd3, 8'h00); cmd(2'd3, 8'h00);
    cmd(2'd0, 8'h7F); cmd(2'd1, 8'h33); cmd(2'd1, 8'h44);
    cmd(2'd2, 8'h7F); cmd(2'd3, 8'h00); cmd(2'd3, 8'h00);
    cmd(2'd2, 8'h2A); cmd(2'd3, 8'h00);
    cyc(1'b1, 1'b1, {2'd3, 8'h00});
    cmd(2'd3, 8'h00);
    cmd(2'd2, 8'h2A); cmd(2'd3, 8'h00);
    for (int n = 0; n < 3000; n++) begin
      logic [7:0] p;
      p = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 127)) : 8'($urandom);
      if ($urandom_range(0, 99) == 0) cyc(1'b1, 1'($urandom_range(0, 1)), {2'($urandom), p});
      else cyc(1'b0, $urandom_range(0, 3) != 0, {2'($urandom), p});
    end
    idle(2);
    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain pending got %0d want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
